// File: rtl/hex_ascii_formatter.sv
// -----------------------------------------------------------------------------
// hex_ascii_formatter
//
// Purpose:
//   Turns each accepted DATA_WIDTH-bit word into one line of fixed-width ASCII
//   hexadecimal text (most significant nibble first) followed by a line ending,
//   delivered as a valid/ready byte stream suitable for a UART transmitter.
//
// Build option:
//   HEX_ASCII_FORMATTER_CRLF_EN  defined   -> lines end in 0x0D 0x0A
//                                undefined -> lines end in 0x0A only
//
// Parameters:
//   DATA_WIDTH  input word width, multiple of 4 (NUM_DIGITS = DATA_WIDTH/4)
//   UPPERCASE   1: nibbles 10-15 map to 'A'-'F'; 0: map to 'a'-'f'
//
// Ports:
//   clock         clock
//   reset         synchronous, active-high reset
//   input_valid   input word valid
//   input_ready   formatter can accept a word (registered, high only in IDLE)
//   input_data    word to format
//   output_valid  ASCII byte valid (registered)
//   output_ready  downstream accepts byte
//   output_data   ASCII byte (registered)
// -----------------------------------------------------------------------------
module hex_ascii_formatter #(
   parameter int DATA_WIDTH = 16,
   parameter bit UPPERCASE  = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  input_valid,
   output logic                  input_ready,
   input  logic [DATA_WIDTH-1:0] input_data,
   output logic                  output_valid,
   input  logic                  output_ready,
   output logic [7:0]            output_data
);

   localparam int NUM_DIGITS = DATA_WIDTH / 4;
   localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

`ifdef HEX_ASCII_FORMATTER_CRLF_EN
   typedef enum logic [1:0] {S_IDLE, S_DIGIT, S_CR, S_LF} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_DIGIT, S_LF} state_t;
`endif

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   word_q, word_d;
   logic                    input_ready_q, input_ready_d;
   logic                    output_valid_q, output_valid_d;
   logic [7:0]              output_data_q, output_data_d;

   logic                    accept;
   logic                    xfer;
   logic [3:0]              nibble [NUM_DIGITS];

   // Nibble view of the latched word; nibble[0] is the least significant.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
      assign nibble[gi] = word_q[gi*4 +: 4];
   end

   // 0x37 = 'A'-10 and 0x57 = 'a'-10, so adding the nibble lands on the letter.
   function automatic logic [7:0] to_ascii(input logic [3:0] n);
      if (n < 4'd10) begin
         return 8'h30 + {4'h0, n};
      end
      return (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, n};
   endfunction

   assign accept = input_valid && input_ready_q;
   assign xfer   = output_valid_q && output_ready;

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      word_d         = word_q;
      input_ready_d  = input_ready_q;
      output_valid_d = output_valid_q;
      output_data_d  = output_data_q;

      case (state_q)
         S_IDLE: begin
            input_ready_d  = 1'b1;
            output_valid_d = 1'b0;
            if (accept) begin
               // First character comes straight from the incoming word so it
               // is on the output the cycle after the accept edge.
               word_d         = input_data;
               idx_d          = IDX_W'(NUM_DIGITS - 1);
               input_ready_d  = 1'b0;
               output_valid_d = 1'b1;
               output_data_d  = to_ascii(input_data[DATA_WIDTH-1 -: 4]);
               state_d        = S_DIGIT;
            end
         end

         S_DIGIT: begin
            if (xfer) begin
               if (idx_q != '0) begin
                  idx_d         = idx_q - IDX_W'(1);
                  output_data_d = to_ascii(nibble[idx_q - IDX_W'(1)]);
               end else begin
`ifdef HEX_ASCII_FORMATTER_CRLF_EN
                  state_d       = S_CR;
                  output_data_d = 8'h0D;
`else
                  state_d       = S_LF;
                  output_data_d = 8'h0A;
`endif
               end
            end
         end

`ifdef HEX_ASCII_FORMATTER_CRLF_EN
         S_CR: begin
            if (xfer) begin
               state_d       = S_LF;
               output_data_d = 8'h0A;
            end
         end
`endif

         S_LF: begin
            if (xfer) begin
               state_d        = S_IDLE;
               output_valid_d = 1'b0;
               input_ready_d  = 1'b1;
            end
         end

         default: begin
            state_d        = S_IDLE;
            output_valid_d = 1'b0;
            input_ready_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_IDLE;
         idx_q          <= '0;
         word_q         <= '0;
         input_ready_q  <= 1'b0;
         output_valid_q <= 1'b0;
         output_data_q  <= 8'h00;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         word_q         <= word_d;
         input_ready_q  <= input_ready_d;
         output_valid_q <= output_valid_d;
         output_data_q  <= output_data_d;
      end
   end

   assign input_ready  = input_ready_q;
   assign output_valid = output_valid_q;
   assign output_data  = output_data_q;

endmodule
